// File: rtl/ordered_uid_tracker.sv
// Allocates internal UIDs to AR requests and releases completed bursts in strict
// per-original-ID order, arbitrating round-robin across IDs.
module ordered_uid_tracker #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned UID_WIDTH  = 4,
    parameter int unsigned MAX_PER_ID = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc_valid,
    input  logic [ID_WIDTH-1:0]  i_alloc_orig_id,
    output logic                 o_alloc_ready,
    output logic [UID_WIDTH-1:0] o_alloc_uid,
    input  logic                 i_cmpl_valid,
    input  logic [UID_WIDTH-1:0] i_cmpl_uid,
    output logic                 o_rel_valid,
    output logic [UID_WIDTH-1:0] o_rel_uid,
    output logic [ID_WIDTH-1:0]  o_rel_orig_id,
    input  logic                 i_rel_ready,
    output logic [UID_WIDTH:0]   o_num_outstanding,
    output logic                 o_err_cmpl
);

    localparam int unsigned NUM_UIDS = 1 << UID_WIDTH;
    localparam int unsigned NUM_IDS  = 1 << ID_WIDTH;
    localparam int unsigned CNT_W    = $clog2(MAX_PER_ID + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PER_ID);

    logic [NUM_UIDS-1:0] r_busy, r_done, r_sel;
    logic [NUM_UIDS-1:0] w_busy_nxt, w_done_nxt, w_sel_nxt;
    logic [ID_WIDTH-1:0] r_orig_id     [NUM_UIDS];
    logic [ID_WIDTH-1:0] w_orig_id_nxt [NUM_UIDS];
    logic [CNT_W-1:0]    r_seq         [NUM_UIDS];
    logic [CNT_W-1:0]    w_seq_nxt     [NUM_UIDS];
    logic [CNT_W-1:0]    r_cnt         [NUM_IDS];
    logic [CNT_W-1:0]    w_cnt_nxt     [NUM_IDS];

    logic [UID_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic                 r_rel_valid, w_rel_valid_nxt;
    logic [UID_WIDTH-1:0] r_rel_uid, w_rel_uid_nxt;
    logic [ID_WIDTH-1:0]  r_rel_orig_id, w_rel_orig_id_nxt;
    logic [UID_WIDTH:0]   r_num_out, w_num_out_nxt;
    logic                 r_err, w_err_nxt;

    logic                 w_free_any;
    logic [UID_WIDTH-1:0] w_free_uid;
    logic                 w_alloc_fire, w_rel_fire, w_cmpl_ok, w_load;
    logic [NUM_UIDS-1:0]  w_elig;
    logic [UID_WIDTH-1:0] w_rr_base, w_idx;
    logic                 w_pick_any;
    logic [UID_WIDTH-1:0] w_pick_uid;

    always_comb begin
        w_free_any = 1'b0;
        w_free_uid = '0;
        for (int i = NUM_UIDS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_any = 1'b1;
                w_free_uid = UID_WIDTH'(i);
            end
        end
    end

    assign o_alloc_uid   = w_free_uid;
    assign o_alloc_ready = i_rst_n & w_free_any & (r_cnt[i_alloc_orig_id] < MAX_CNT);

    assign w_alloc_fire = i_alloc_valid & o_alloc_ready;
    assign w_rel_fire   = r_rel_valid & i_rel_ready;
    assign w_cmpl_ok    = i_cmpl_valid & r_busy[i_cmpl_uid] & ~r_done[i_cmpl_uid];
    assign w_load       = ~r_rel_valid | w_rel_fire;
    assign w_rr_base    = w_rel_fire ? r_rel_uid + UID_WIDTH'(1) : r_rr_ptr;

    // During a handshake the same-ID successor (seq==1) already counts as head,
    // so an in-order chain drains on consecutive cycles.
    always_comb begin
        for (int i = 0; i < NUM_UIDS; i++) begin
            w_elig[i] = r_busy[i] & r_done[i] & ~r_sel[i] &
                        ((r_seq[i] == '0) |
                         (w_rel_fire & (r_orig_id[i] == r_rel_orig_id) &
                          (r_seq[i] == CNT_W'(1))));
        end
    end

    always_comb begin
        w_pick_any = 1'b0;
        w_pick_uid = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_UIDS; k++) begin
            w_idx = w_rr_base + UID_WIDTH'(k);
            if (!w_pick_any && w_elig[w_idx]) begin
                w_pick_any = 1'b1;
                w_pick_uid = w_idx;
            end
        end
    end

    always_comb begin
        w_busy_nxt        = r_busy;
        w_done_nxt        = r_done;
        w_sel_nxt         = r_sel;
        w_orig_id_nxt     = r_orig_id;
        w_seq_nxt         = r_seq;
        w_cnt_nxt         = r_cnt;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_rel_valid_nxt   = r_rel_valid;
        w_rel_uid_nxt     = r_rel_uid;
        w_rel_orig_id_nxt = r_rel_orig_id;
        w_num_out_nxt     = r_num_out;
        w_err_nxt         = i_cmpl_valid & ~w_cmpl_ok;

        if (w_cmpl_ok) begin
            w_done_nxt[i_cmpl_uid] = 1'b1;
        end

        if (w_rel_fire) begin
            for (int i = 0; i < NUM_UIDS; i++) begin
                if (r_busy[i] && (r_orig_id[i] == r_rel_orig_id) &&
                    (UID_WIDTH'(i) != r_rel_uid)) begin
                    w_seq_nxt[i] = r_seq[i] - CNT_W'(1);
                end
            end
            w_busy_nxt[r_rel_uid]      = 1'b0;
            w_done_nxt[r_rel_uid]      = 1'b0;
            w_sel_nxt[r_rel_uid]       = 1'b0;
            w_cnt_nxt[r_rel_orig_id]   = r_cnt[r_rel_orig_id] - CNT_W'(1);
            w_rr_ptr_nxt               = r_rel_uid + UID_WIDTH'(1);
        end

        // Age is taken after any same-ID release so the new entry lands at the tail.
        if (w_alloc_fire) begin
            w_busy_nxt[w_free_uid]       = 1'b1;
            w_done_nxt[w_free_uid]       = 1'b0;
            w_sel_nxt[w_free_uid]        = 1'b0;
            w_orig_id_nxt[w_free_uid]    = i_alloc_orig_id;
            w_seq_nxt[w_free_uid]        = w_cnt_nxt[i_alloc_orig_id];
            w_cnt_nxt[i_alloc_orig_id]   = w_cnt_nxt[i_alloc_orig_id] + CNT_W'(1);
        end

        if (w_load) begin
            w_rel_valid_nxt = w_pick_any;
            if (w_pick_any) begin
                w_rel_uid_nxt         = w_pick_uid;
                w_rel_orig_id_nxt     = r_orig_id[w_pick_uid];
                w_sel_nxt[w_pick_uid] = 1'b1;
            end
        end

        if (w_alloc_fire && !w_rel_fire) begin
            w_num_out_nxt = r_num_out + (UID_WIDTH + 1)'(1);
        end else if (!w_alloc_fire && w_rel_fire) begin
            w_num_out_nxt = r_num_out - (UID_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy        <= '0;
            r_done        <= '0;
            r_sel         <= '0;
            for (int i = 0; i < NUM_UIDS; i++) begin
                r_orig_id[i] <= '0;
                r_seq[i]     <= '0;
            end
            for (int i = 0; i < NUM_IDS; i++) begin
                r_cnt[i] <= '0;
            end
            r_rr_ptr      <= '0;
            r_rel_valid   <= 1'b0;
            r_rel_uid     <= '0;
            r_rel_orig_id <= '0;
            r_num_out     <= '0;
            r_err         <= 1'b0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_sel         <= w_sel_nxt;
            r_orig_id     <= w_orig_id_nxt;
            r_seq         <= w_seq_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_rel_valid   <= w_rel_valid_nxt;
            r_rel_uid     <= w_rel_uid_nxt;
            r_rel_orig_id <= w_rel_orig_id_nxt;
            r_num_out     <= w_num_out_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign o_rel_valid       = r_rel_valid;
    assign o_rel_uid         = r_rel_uid;
    assign o_rel_orig_id     = r_rel_orig_id;
    assign o_num_outstanding = r_num_out;
    assign o_err_cmpl        = r_err;

endmodule

// File: tb/tb_ordered_uid_tracker.sv
// Bench for ordered_uid_tracker: directed scenarios plus random traffic, all checked
// against a per-ID FIFO model of allocation order and completion state.
module tb_ordered_uid_tracker;

    localparam int NU   = 16;
    localparam int NI   = 16;
    localparam int MAXP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid;
    logic [3:0] alloc_orig_id;
    logic       alloc_ready;
    logic [3:0] alloc_uid;
    logic       cmpl_valid;
    logic [3:0] cmpl_uid;
    logic       rel_valid;
    logic [3:0] rel_uid;
    logic [3:0] rel_orig_id;
    logic       rel_ready;
    logic [4:0] num_outstanding;
    logic       err_cmpl;

    ordered_uid_tracker #(
        .ID_WIDTH  (4),
        .UID_WIDTH (4),
        .MAX_PER_ID(MAXP)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_alloc_valid    (alloc_valid),
        .i_alloc_orig_id  (alloc_orig_id),
        .o_alloc_ready    (alloc_ready),
        .o_alloc_uid      (alloc_uid),
        .i_cmpl_valid     (cmpl_valid),
        .i_cmpl_uid       (cmpl_uid),
        .o_rel_valid      (rel_valid),
        .o_rel_uid        (rel_uid),
        .o_rel_orig_id    (rel_orig_id),
        .i_rel_ready      (rel_ready),
        .o_num_outstanding(num_outstanding),
        .o_err_cmpl       (err_cmpl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each ID keeps a FIFO of its UIDs in allocation order; head = oldest.
    bit m_busy [NU];
    bit m_done [NU];
    int m_id   [NU];
    int q      [NI][$];
    bit m_rv;
    int m_ru, m_rid, m_rr, m_nout;
    bit m_err;

    logic       s_alloc_ready;
    logic [3:0] s_alloc_uid;

    task automatic model_reset();
        for (int i = 0; i < NU; i++) begin
            m_busy[i] = 0;
            m_done[i] = 0;
            m_id[i]   = 0;
        end
        for (int i = 0; i < NI; i++) q[i].delete();
        m_rv = 0; m_ru = 0; m_rid = 0; m_rr = 0; m_nout = 0; m_err = 0;
    endtask

    task automatic do_reset();
        alloc_valid = 0; alloc_orig_id = 0; cmpl_valid = 0; cmpl_uid = 0; rel_ready = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic step(input bit av, input int aid, input bit cv, input int cu, input bit rr);
        bit free_any, exp_rdy, afire, rfire, cok, load, got;
        int exp_uid, base, u, pick;
        alloc_valid = av; alloc_orig_id = 4'(aid);
        cmpl_valid = cv; cmpl_uid = 4'(cu); rel_ready = rr;
        #1;
        free_any = 0; exp_uid = 0;
        for (int i = NU - 1; i >= 0; i--) if (!m_busy[i]) begin free_any = 1; exp_uid = i; end
        exp_rdy = free_any && (q[aid].size() < MAXP);
        n_checks++;
        if (alloc_ready !== exp_rdy) begin
            n_errors++;
            $display("FAIL alloc_ready got %0d want %0d (id %0d)", alloc_ready, exp_rdy, aid);
        end
        n_checks++;
        if (alloc_uid !== 4'(exp_uid)) begin
            n_errors++;
            $display("FAIL alloc_uid got %0d want %0d", alloc_uid, exp_uid);
        end
        s_alloc_ready = alloc_ready;
        s_alloc_uid   = alloc_uid;

        afire = av && exp_rdy;
        rfire = m_rv && rr;
        cok   = cv && m_busy[cu] && !m_done[cu];
        load  = !m_rv || rfire;
        if (rfire) begin
            void'(q[m_rid].pop_front());
            m_busy[m_ru] = 0;
            m_done[m_ru] = 0;
        end
        got = 0; pick = 0;
        if (load) begin
            base = rfire ? (m_ru + 1) % NU : m_rr;
            for (int k = 0; k < NU; k++) begin
                u = (base + k) % NU;
                if (!got && m_busy[u] && m_done[u] && q[m_id[u]][0] == u) begin
                    got = 1; pick = u;
                end
            end
        end
        if (rfire) m_rr = (m_ru + 1) % NU;
        if (load) begin
            m_rv = got;
            if (got) begin m_ru = pick; m_rid = m_id[pick]; end
        end
        if (cok) m_done[cu] = 1;
        if (afire) begin
            m_busy[exp_uid] = 1; m_done[exp_uid] = 0; m_id[exp_uid] = aid;
            q[aid].push_back(exp_uid);
        end
        m_err  = cv && !cok;
        m_nout = m_nout + int'(afire) - int'(rfire);

        @(posedge clk);
        #1;
        n_checks++;
        if (rel_valid !== m_rv) begin
            n_errors++;
            $display("FAIL rel_valid got %0d want %0d", rel_valid, m_rv);
        end
        if (m_rv) begin
            n_checks++;
            if (rel_uid !== 4'(m_ru) || rel_orig_id !== 4'(m_rid)) begin
                n_errors++;
                $display("FAIL rel_uid/id got %0d/%0d want %0d/%0d",
                         rel_uid, rel_orig_id, m_ru, m_rid);
            end
        end
        n_checks++;
        if (num_outstanding !== 5'(m_nout)) begin
            n_errors++;
            $display("FAIL num_outstanding got %0d want %0d", num_outstanding, m_nout);
        end
        n_checks++;
        if (err_cmpl !== m_err) begin
            n_errors++;
            $display("FAIL err_cmpl got %0d want %0d", err_cmpl, m_err);
        end
    endtask

    task automatic drain();
        int cu;
        bit cv;
        bit done_ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (m_nout == 0 && !m_rv) begin done_ok = 1; break; end
            cv = 0; cu = 0;
            for (int i = NU - 1; i >= 0; i--) if (m_busy[i] && !m_done[i]) begin cv = 1; cu = i; end
            step(0, 0, cv, cu, 1);
        end
        n_checks++;
        if (!done_ok || num_outstanding !== 5'd0) begin
            n_errors++;
            $display("FAIL drain got %0d outstanding want 0", num_outstanding);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; alloc_valid = 1; alloc_orig_id = 4'd3; cmpl_valid = 0; cmpl_uid = 0;
        rel_ready = 1;
        model_reset();
        #1;
        n_checks++;
        if (rel_valid !== 0 || rel_uid !== 0 || rel_orig_id !== 0 || num_outstanding !== 0 ||
            err_cmpl !== 0) begin
            n_errors++;
            $display("FAIL reset_regs got rv%0d ru%0d rid%0d n%0d e%0d want all 0",
                     rel_valid, rel_uid, rel_orig_id, num_outstanding, err_cmpl);
        end
        n_checks++;
        if (alloc_ready !== 0 || alloc_uid !== 0) begin
            n_errors++;
            $display("FAIL reset_alloc got rdy%0d uid%0d want 0/0", alloc_ready, alloc_uid);
        end
        @(posedge clk);
        #1 rst_n = 1; alloc_valid = 0;
        #1;
        n_checks++;
        if (alloc_ready !== 1) begin
            n_errors++;
            $display("FAIL ready_after_reset got %0d want 1", alloc_ready);
        end
    endtask

    task automatic test_in_order_release();
        int ids [3] = '{3, 3, 5};
        for (int i = 0; i < 3; i++) begin
            step(1, ids[i], 0, 0, 1);
            n_checks++;
            if (s_alloc_uid !== 4'(i)) begin
                n_errors++;
                $display("FAIL alloc_seq got %0d want %0d", s_alloc_uid, i);
            end
        end
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 2, 1);
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (rel_valid !== 1 || rel_uid !== 4'd2 || rel_orig_id !== 4'd5) begin
            n_errors++;
            $display("FAIL first_rel got v%0d %0d/%0d want 1 2/5", rel_valid, rel_uid, rel_orig_id);
        end
        step(0, 0, 1, 0, 1);
        n_checks++;
        if (rel_valid !== 0) begin
            n_errors++;
            $display("FAIL uid1_withheld got rel_valid %0d uid %0d want 0", rel_valid, rel_uid);
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (rel_valid !== 1 || rel_uid !== 4'd0 || rel_orig_id !== 4'd3) begin
            n_errors++;
            $display("FAIL rel_head got v%0d %0d/%0d want 1 0/3", rel_valid, rel_uid, rel_orig_id);
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (rel_valid !== 1 || rel_uid !== 4'd1 || rel_orig_id !== 4'd3) begin
            n_errors++;
            $display("FAIL back_to_back got v%0d %0d/%0d want 1 1/3", rel_valid, rel_uid, rel_orig_id);
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (rel_valid !== 0 || num_outstanding !== 0) begin
            n_errors++;
            $display("FAIL order_empty got v%0d n%0d want 0 0", rel_valid, num_outstanding);
        end
    endtask

    task automatic test_per_id_limit();
        repeat (4) step(1, 7, 0, 0, 1);
        step(0, 7, 0, 0, 1);
        n_checks++;
        if (s_alloc_ready !== 0) begin
            n_errors++;
            $display("FAIL limit_id7 got %0d want 0", s_alloc_ready);
        end
        step(0, 2, 0, 0, 1);
        n_checks++;
        if (s_alloc_ready !== 1) begin
            n_errors++;
            $display("FAIL other_id_ready got %0d want 1", s_alloc_ready);
        end
        step(0, 7, 1, 0, 1);
        step(0, 7, 0, 0, 1);
        step(0, 7, 0, 0, 1);
        n_checks++;
        if (s_alloc_ready !== 0) begin
            n_errors++;
            $display("FAIL limit_during_release got %0d want 0", s_alloc_ready);
        end
        step(0, 7, 0, 0, 0);
        n_checks++;
        if (s_alloc_ready !== 1) begin
            n_errors++;
            $display("FAIL ready_after_release got %0d want 1", s_alloc_ready);
        end
        drain();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < NU; i++) begin
            step(1, i, 0, 0, 1);
            n_checks++;
            if (s_alloc_uid !== 4'(i)) begin
                n_errors++;
                $display("FAIL fill_uid got %0d want %0d", s_alloc_uid, i);
            end
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (s_alloc_ready !== 0 || num_outstanding !== 5'd16) begin
            n_errors++;
            $display("FAIL full got rdy%0d n%0d want 0 16", s_alloc_ready, num_outstanding);
        end
        step(0, 9, 1, 9, 1);
        step(0, 9, 0, 0, 1);
        step(0, 9, 0, 0, 1);
        n_checks++;
        if (s_alloc_ready !== 0) begin
            n_errors++;
            $display("FAIL freed_not_yet got %0d want 0", s_alloc_ready);
        end
        step(1, 9, 0, 0, 1);
        n_checks++;
        if (s_alloc_ready !== 1 || s_alloc_uid !== 4'd9) begin
            n_errors++;
            $display("FAIL realloc_9 got rdy%0d uid%0d want 1 9", s_alloc_ready, s_alloc_uid);
        end
    endtask

    task automatic test_round_robin();
        int want [3] = '{0, 4, 8};
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 4, 0);
        step(0, 0, 1, 8, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rel_valid !== 1 || rel_uid !== 4'(want[i])) begin
                n_errors++;
                $display("FAIL rr_order got v%0d uid%0d want %0d", rel_valid, rel_uid, want[i]);
            end
            if (i < 2) step(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, (i < 2), (i == 0) ? 2 : 9, 0);
            n_checks++;
            if (rel_valid !== 1 || rel_uid !== 4'd8) begin
                n_errors++;
                $display("FAIL hold got v%0d uid%0d want 1 8", rel_valid, rel_uid);
            end
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (rel_uid !== 4'd9) begin
            n_errors++;
            $display("FAIL rr_wrap_first got %0d want 9", rel_uid);
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (rel_uid !== 4'd2) begin
            n_errors++;
            $display("FAIL rr_wrap_second got %0d want 2", rel_uid);
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (rel_valid !== 0) begin
            n_errors++;
            $display("FAIL rr_idle got %0d want 0", rel_valid);
        end
    endtask

    task automatic test_errors();
        step(0, 0, 1, 0, 1);
        n_checks++;
        if (err_cmpl !== 1) begin
            n_errors++;
            $display("FAIL err_free_uid got %0d want 1", err_cmpl);
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (err_cmpl !== 0) begin
            n_errors++;
            $display("FAIL err_one_cycle got %0d want 0", err_cmpl);
        end
        step(0, 0, 1, 5, 0);
        step(0, 0, 1, 5, 0);
        n_checks++;
        if (err_cmpl !== 1) begin
            n_errors++;
            $display("FAIL err_done_uid got %0d want 1", err_cmpl);
        end
        step(0, 0, 1, 5, 0);
        n_checks++;
        if (err_cmpl !== 1 || num_outstanding !== 5'd11) begin
            n_errors++;
            $display("FAIL err_again got e%0d n%0d want 1 11", err_cmpl, num_outstanding);
        end
    endtask

    task automatic test_reset_mid();
        n_checks++;
        if (rel_valid !== 1) begin
            n_errors++;
            $display("FAIL pre_reset_pending got %0d want 1", rel_valid);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if (rel_valid !== 0 || num_outstanding !== 0 || alloc_ready !== 0 || alloc_uid !== 0) begin
            n_errors++;
            $display("FAIL async_reset got rv%0d n%0d rdy%0d uid%0d want 0",
                     rel_valid, num_outstanding, alloc_ready, alloc_uid);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit av, cv, rr;
        int aid, cu, start;
        for (int n = 0; n < 3000; n++) begin
            av  = ($urandom_range(0, 99) < 55);
            aid = $urandom_range(0, 3);
            cv  = ($urandom_range(0, 99) < 50);
            cu  = $urandom_range(0, NU - 1);
            if ($urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, NU - 1);
                for (int k = NU - 1; k >= 0; k--) begin
                    if (m_busy[(start + k) % NU] && !m_done[(start + k) % NU]) cu = (start + k) % NU;
                end
            end
            rr = ($urandom_range(0, 99) < 70);
            step(av, aid, cv, cu, rr);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_in_order_release();
        test_per_id_limit();
        test_fill();
        test_round_robin();
        test_hold();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
